// File: rtl/sync_uart_rx_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : sync_uart_rx_unpacker
// Purpose  : Captures one received UART frame and replays it as a byte stream
//            (opt, len, payload) with valid/ready and a last flag.
//            Optional skid frame register: SYNC_UART_UNPACK_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sync_uart_rx_unpacker #(
    parameter int BYTE_SIZE     = 8,
    parameter int MAX_MSG_LEN   = (1 << BYTE_SIZE) - 1,
    parameter int OUT_DATA_SIZE = $clog2(MAX_MSG_LEN) * BYTE_SIZE
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [BYTE_SIZE-1:0]     in_opt,
    input  logic [BYTE_SIZE-1:0]     in_len,
    input  logic [OUT_DATA_SIZE-1:0] in_data,
    input  logic                     in_valid,
    output logic [BYTE_SIZE-1:0]     o_data,
    output logic                     o_valid,
    output logic                     o_last,
    input  logic                     i_ready,
    output logic                     o_busy,
    output logic                     o_len_trunc,
    output logic                     o_overrun
);

    localparam int DATA_BYTES = OUT_DATA_SIZE / BYTE_SIZE;
    localparam int c_idx_w    = $clog2(DATA_BYTES + 1);
    localparam logic [BYTE_SIZE-1:0] c_max_eff  = BYTE_SIZE'(DATA_BYTES);
    localparam logic [c_idx_w-1:0]   c_db_idx   = c_idx_w'(DATA_BYTES);
    localparam logic [c_idx_w-1:0]   c_idx_one  = c_idx_w'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPT  = 2'd1;
    localparam logic [1:0] ST_LEN  = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [BYTE_SIZE-1:0]     r_opt;
    logic [BYTE_SIZE-1:0]     r_len;
    logic [OUT_DATA_SIZE-1:0] r_data;
    logic [c_idx_w-1:0]       r_eff;
    logic [c_idx_w-1:0]       r_idx;
    logic [c_idx_w-1:0]       w_idx_nxt;
    logic [OUT_DATA_SIZE-1:0] w_shift;
    logic                     r_len_trunc;
    logic                     r_overrun;
    logic                     w_xfer;
    logic                     w_final;
    logic                     w_idle;
    logic                     w_sk_busy;

    // Frame source selected for loading into the active register
    logic                     w_ld;
    logic                     w_drop;
    logic [BYTE_SIZE-1:0]     w_ld_opt;
    logic [BYTE_SIZE-1:0]     w_ld_len;
    logic [OUT_DATA_SIZE-1:0] w_ld_data;
    logic                     w_ld_trunc;
    logic [c_idx_w-1:0]       w_ld_eff;

    assign w_idle  = (r_state == ST_IDLE);
    assign o_valid = !w_idle;
    assign w_xfer  = o_valid && i_ready;
    assign w_final = w_xfer && o_last;
    assign w_shift = r_data << (32'(r_idx) * BYTE_SIZE);

    always_comb begin
        o_data = '0;
        o_last = 1'b0;
        case (r_state)
            ST_OPT:  o_data = r_opt;
            ST_LEN: begin
                o_data = r_len;
                o_last = (r_eff == '0);
            end
            ST_DATA: begin
                o_data = w_shift[OUT_DATA_SIZE-1 -: BYTE_SIZE];
                o_last = (r_idx == (r_eff - c_idx_one));
            end
            default: ;
        endcase
    end

`ifdef SYNC_UART_UNPACK_SKID_EN
    logic                     r_sk_vld;
    logic [BYTE_SIZE-1:0]     r_sk_opt;
    logic [BYTE_SIZE-1:0]     r_sk_len;
    logic [OUT_DATA_SIZE-1:0] r_sk_data;
    logic                     w_sk_wr;
    logic                     w_sk_clr;

    always_comb begin
        w_ld      = 1'b0;
        w_drop    = 1'b0;
        w_sk_wr   = 1'b0;
        w_sk_clr  = 1'b0;
        w_ld_opt  = in_opt;
        w_ld_len  = in_len;
        w_ld_data = in_data;
        if (w_idle) begin
            w_ld = in_valid;
        end else if (w_final) begin
            if (r_sk_vld) begin
                // Promote the skid frame; a simultaneous arrival refills it
                w_ld      = 1'b1;
                w_ld_opt  = r_sk_opt;
                w_ld_len  = r_sk_len;
                w_ld_data = r_sk_data;
                w_sk_wr   = in_valid;
                w_sk_clr  = !in_valid;
            end else begin
                w_ld = in_valid;
            end
        end else if (in_valid) begin
            w_drop  = r_sk_vld;
            w_sk_wr = !r_sk_vld;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sk_vld  <= 1'b0;
            r_sk_opt  <= '0;
            r_sk_len  <= '0;
            r_sk_data <= '0;
        end else if (w_sk_wr) begin
            r_sk_vld  <= 1'b1;
            r_sk_opt  <= in_opt;
            r_sk_len  <= in_len;
            r_sk_data <= in_data;
        end else if (w_sk_clr) begin
            r_sk_vld  <= 1'b0;
        end
    end

    assign w_sk_busy = r_sk_vld;
`else
    always_comb begin
        w_ld      = in_valid && (w_idle || w_final);
        w_drop    = in_valid && !w_idle && !w_final;
        w_ld_opt  = in_opt;
        w_ld_len  = in_len;
        w_ld_data = in_data;
    end

    assign w_sk_busy = 1'b0;
`endif

    assign w_ld_trunc = (w_ld_len > c_max_eff);
    assign w_ld_eff   = w_ld_trunc ? c_db_idx : w_ld_len[c_idx_w-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: ;
            ST_OPT: if (w_xfer) w_state_nxt = ST_LEN;
            ST_LEN: if (w_xfer) begin
                w_state_nxt = (r_eff == '0) ? ST_IDLE : ST_DATA;
                w_idx_nxt   = '0;
            end
            ST_DATA: if (w_xfer) begin
                if (o_last) w_state_nxt = ST_IDLE;
                else        w_idx_nxt   = r_idx + c_idx_one;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_ld) w_state_nxt = ST_OPT;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_opt       <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_eff       <= '0;
            r_len_trunc <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_len_trunc <= w_ld && w_ld_trunc;
            r_overrun   <= w_drop;
            if (w_ld) begin
                r_opt  <= w_ld_opt;
                r_len  <= w_ld_len;
                r_data <= w_ld_data;
                r_eff  <= w_ld_eff;
            end
        end
    end

    assign o_busy      = !w_idle || w_sk_busy;
    assign o_len_trunc = r_len_trunc;
    assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sync_uart_rx_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_uart_rx_unpacker
// Purpose  : Directed self-checking bench for sync_uart_rx_unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_uart_rx_unpacker;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  in_opt;
    logic [7:0]  in_len;
    logic [63:0] in_data;
    logic        in_valid;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_last;
    logic        i_ready;
    logic        o_busy;
    logic        o_len_trunc;
    logic        o_overrun;

    int checks = 0;
    int errors = 0;

    sync_uart_rx_unpacker dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_opt      (in_opt),
        .in_len      (in_len),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_len_trunc (o_len_trunc),
        .o_overrun   (o_overrun)
    );

    always #5 CLK = ~CLK;

    // Called at a negedge; returns at the negedge where the opt beat shows
    task automatic send_frame(input logic [7:0] opt, input logic [7:0] len, input logic [63:0] data);
        in_opt   = opt;
        in_len   = len;
        in_data  = data;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({o_valid, o_last, o_busy, o_len_trunc, o_overrun, o_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b t=%b o=%b d=%h, expected all 0",
                     o_valid, o_last, o_busy, o_len_trunc, o_overrun, o_data);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got v=%b b=%b, expected 0 0", o_valid, o_busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [5];
        exp = '{8'h11, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        i_ready = 1'b1;
        send_frame(8'h11, 8'h03, 64'hAABBCC00_00000000);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp[k] || o_last !== (k == 4) || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_beat%0d: got v=%b d=%h l=%b b=%b, expected v=1 d=%h l=%b b=1",
                         k, o_valid, o_data, o_last, o_busy, exp[k], (k == 4));
            end
            @(negedge CLK);
        end
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got b=%b v=%b, expected 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_zero_len();
        i_ready = 1'b1;
        send_frame(8'h5A, 8'h00, 64'hDEADBEEF_CAFEF00D);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h5A || o_last !== 1'b0) begin
            errors++;
            $display("FAIL zero_opt: got v=%b d=%h l=%b, expected v=1 d=5a l=0", o_valid, o_data, o_last);
        end
        @(negedge CLK);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h00 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL zero_len: got v=%b d=%h l=%b, expected v=1 d=00 l=1", o_valid, o_data, o_last);
        end
        @(negedge CLK);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got v=%b b=%b, expected 0 0", o_valid, o_busy);
        end
    endtask

    task automatic test_trunc();
        int pulses;
        logic [7:0] e;
        i_ready = 1'b1;
        pulses  = 0;
        send_frame(8'h3C, 8'h0C, 64'h01020304_05060708);
        for (int k = 0; k < 10; k++) begin
            if (o_len_trunc === 1'b1) pulses++;
            e = (k == 0) ? 8'h3C : (k == 1) ? 8'h0C : 8'(k - 1);
            checks++;
            if (o_valid !== 1'b1 || o_data !== e || o_last !== (k == 9)) begin
                errors++;
                $display("FAIL trunc_beat%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                         k, o_valid, o_data, o_last, e, (k == 9));
            end
            @(negedge CLK);
        end
        if (o_len_trunc === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL trunc_pulse: got pulses=%0d v=%b, expected pulses=1 v=0", pulses, o_valid);
        end
        // Exactly DATA_BYTES is not a truncation
        send_frame(8'h77, 8'h08, 64'h01020304_05060708);
        checks++;
        if (o_len_trunc !== 1'b0) begin
            errors++;
            $display("FAIL trunc_len8: got o_len_trunc=%b, expected 0", o_len_trunc);
        end
        repeat (9) @(negedge CLK);
        checks++;
        if (o_data !== 8'h08 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL trunc_len8_last: got d=%h l=%b, expected d=08 l=1", o_data, o_last);
        end
        @(negedge CLK);
    endtask

    task automatic test_stall();
        logic [7:0] exp [7];
        int k;
        exp = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        k = 0;
        i_ready = 1'b0;
        send_frame(8'hA5, 8'h05, 64'h11223344_55000000);
        for (int cyc = 0; cyc < 200 && k < 7; cyc++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp[k] || o_last !== (k == 6)) begin
                errors++;
                $display("FAIL stall_beat%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                         k, o_valid, o_data, o_last, exp[k], (k == 6));
            end
            i_ready = 1'($urandom_range(0, 1));
            if (i_ready) k++;
            @(negedge CLK);
        end
        checks++;
        if (k != 7 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_complete: got beats=%0d b=%b, expected beats=7 b=0", k, o_busy);
        end
        i_ready = 1'b1;
    endtask

    task automatic test_overrun();
        i_ready = 1'b1;
        send_frame(8'h21, 8'h02, 64'hC1C20000_00000000);
        in_opt = 8'h31; in_len = 8'h01; in_data = 64'h99000000_00000000; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
`ifdef SYNC_UART_UNPACK_SKID_EN
        checks++;
        if (o_overrun !== 1'b0 || o_data !== 8'h02) begin
            errors++;
            $display("FAIL skid_no_overrun: got o=%b d=%h, expected o=0 d=02", o_overrun, o_data);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (o_data !== 8'hC2 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL skid_first_last: got d=%h l=%b, expected d=c2 l=1", o_data, o_last);
        end
        @(negedge CLK);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h31 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL skid_promote: got v=%b d=%h b=%b, expected v=1 d=31 b=1", o_valid, o_data, o_busy);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (o_data !== 8'h99 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL skid_second_last: got d=%h l=%b, expected d=99 l=1", o_data, o_last);
        end
        @(negedge CLK);
`else
        checks++;
        if (o_overrun !== 1'b1 || o_data !== 8'h02) begin
            errors++;
            $display("FAIL overrun_pulse: got o=%b d=%h, expected o=1 d=02", o_overrun, o_data);
        end
        @(negedge CLK);
        checks++;
        if (o_overrun !== 1'b0 || o_data !== 8'hC1) begin
            errors++;
            $display("FAIL overrun_continue: got o=%b d=%h, expected o=0 d=c1", o_overrun, o_data);
        end
        @(negedge CLK);
        checks++;
        if (o_data !== 8'hC2 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL overrun_last: got d=%h l=%b, expected d=c2 l=1", o_data, o_last);
        end
        @(negedge CLK);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_dropped: got v=%b b=%b, expected 0 0", o_valid, o_busy);
        end
`endif
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        send_frame(8'h41, 8'h00, 64'h0);
        @(negedge CLK);
        // Final beat of the first frame transfers at the same edge as this in_valid
        in_opt = 8'h51; in_len = 8'h01; in_data = 64'h99000000_00000000; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h51 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_opt: got v=%b d=%h o=%b, expected v=1 d=51 o=0", o_valid, o_data, o_overrun);
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (o_data !== 8'h99 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last: got d=%h l=%b, expected d=99 l=1", o_data, o_last);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1;
        send_frame(8'h61, 8'h05, 64'hE0E1E2E3_E4000000);
        repeat (4) @(negedge CLK);
        checks++;
        if (o_data !== 8'hE2) begin
            errors++;
            $display("FAIL rstmid_idx2: got d=%h, expected e2", o_data);
        end
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        checks++;
        if ({o_valid, o_last, o_busy, o_len_trunc, o_overrun, o_data} !== 13'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got v=%b l=%b b=%b t=%b o=%b d=%h, expected all 0",
                     o_valid, o_last, o_busy, o_len_trunc, o_overrun, o_data);
        end
        @(negedge CLK);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_partial: got v=%b, expected 0", o_valid);
        end
        send_frame(8'h71, 8'h01, 64'hF1000000_00000000);
        checks++;
        if (o_data !== 8'h71 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_new_opt: got v=%b d=%h, expected v=1 d=71", o_valid, o_data);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (o_data !== 8'hF1 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_new_last: got d=%h l=%b, expected d=f1 l=1", o_data, o_last);
        end
        @(negedge CLK);
    endtask

    initial begin
        RST_N    = 1'b0;
        in_opt   = 8'h00;
        in_len   = 8'h00;
        in_data  = 64'h0;
        in_valid = 1'b0;
        i_ready  = 1'b0;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_zero_len();
        test_trunc();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_uart_rx_unpacker.md
Name: sync_uart_rx_unpacker

Overview:
- Downstream stage of the synchronous UART frame receiver.
- Captures one received frame on a single-cycle valid pulse: option byte, length byte, and a wide data bus holding up to DATA_BYTES payload bytes.
- Replays the frame as a byte stream with valid/ready handshake and a last flag, in this order: opt, len, payload bytes in arrival order.
- Feeds the command decoder, which then never touches the wide data bus.

Parameters:
- BYTE_SIZE, 8, bits per byte.
- MAX_MSG_LEN, (1<<BYTE_SIZE)-1, maximum length field value.
- OUT_DATA_SIZE, $clog2(MAX_MSG_LEN)*BYTE_SIZE, width of the captured data bus (64 by default).
- DATA_BYTES (localparam), OUT_DATA_SIZE/BYTE_SIZE, payload bytes held on the bus (8 by default).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- in_opt  in  BYTE_SIZE  frame option byte.
- in_len  in  BYTE_SIZE  frame length field.
- in_data  in  OUT_DATA_SIZE  payload, MSB-aligned. Payload byte 0 (first received) is at [OUT_DATA_SIZE-1 -: BYTE_SIZE]; byte i is at [OUT_DATA_SIZE-1-i*BYTE_SIZE -: BYTE_SIZE].
- in_valid  in  1  one-cycle frame-valid pulse; no back-pressure toward the receiver.
- o_data  out  BYTE_SIZE  stream byte.
- o_valid  out  1  stream byte valid.
- o_last  out  1  final beat of the frame; qualified by o_valid.
- i_ready  in  1  consumer ready.
- o_busy  out  1  a frame is held or streaming.
- o_len_trunc  out  1  one-cycle pulse: captured length exceeded DATA_BYTES.
- o_overrun  out  1  one-cycle pulse: frame dropped.

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - State goes to ST_IDLE.
  - o_valid, o_last, o_busy, o_len_trunc, o_overrun all 0; o_data 0.
  - Captured registers are cleared.
  - Reset mid-stream abandons the frame; no partial beats are emitted after reset.
- States: ST_IDLE, ST_OPT, ST_LEN, ST_DATA.
- Capture:
  - in_valid in ST_IDLE latches opt, len, data and an effective count eff_len = min(in_len, DATA_BYTES).
  - The next state is ST_OPT, so o_valid rises in the cycle after in_valid (latency 1).
  - If in_len > DATA_BYTES, o_len_trunc pulses in that same next cycle.
- Beat transfer happens on o_valid && i_ready. While o_valid=1 and i_ready=0, o_data and o_last hold stable.
- ST_OPT: o_data = opt, o_last = 0. On transfer go to ST_LEN.
- ST_LEN: o_data = len (the original in_len value, not eff_len).
  - If eff_len == 0: o_last = 1, and transfer returns to ST_IDLE.
  - Otherwise: o_last = 0; transfer goes to ST_DATA with byte index 0.
- ST_DATA: o_data = payload byte[index]; o_last = (index == eff_len-1).
  - Transfer increments index.
  - Transfer with o_last returns to ST_IDLE.
  - The index counter is $clog2(DATA_BYTES+1) bits wide and never wraps, because eff_len <= DATA_BYTES.
- o_busy = (state != ST_IDLE).
- Back-to-back frames:
  - in_valid in the same cycle as the final beat's transfer is accepted with no overrun.
  - The new frame's opt beat is valid on the following cycle; there is no idle bubble.
- Overrun:
  - in_valid while busy, and not on the final-transfer cycle, drops the new frame.
  - o_overrun pulses on the following cycle.
  - The current frame continues unchanged.
- in_valid together with in_len=0 and in_data ignored still yields the two beats opt, len.

Optional Feature:
- Macro SYNC_UART_UNPACK_SKID_EN.
- Defined:
  - A second frame register (skid) holds one frame that arrives while busy; o_overrun is not raised for it.
  - On the final-beat transfer, the skid frame is promoted and its opt beat is valid on the next cycle.
  - A third frame arriving while the skid is full is dropped with an o_overrun pulse.
  - o_busy stays 1 while either register is occupied.
- Undefined: single register only; behaviour exactly as in Behaviour.

Test Plan:
- Frame opt=0x11, len=3, in_data=0xAABBCC00_00000000, i_ready held at 1 -> beats 0x11, 0x03, 0xAA, 0xBB, 0xCC on consecutive cycles starting 1 cycle after in_valid; o_last only on 0xCC; o_busy is 0 the cycle after.
- len=0, opt=0x5A -> exactly two beats, 0x5A then 0x00; o_last on 0x00; no data beats.
- len=12 with 8 bytes 0x01..0x08 on the bus -> o_len_trunc pulses once; beats are opt, 0x0C, then 0x01..0x08; o_last on 0x08.
- Random i_ready toggling (about 50%) over a len=5 frame -> o_data/o_last never change while stalled; byte order is intact.
- Second in_valid mid-frame -> o_overrun pulses 1 cycle later and the first frame completes. With SYNC_UART_UNPACK_SKID_EN: no overrun, and the second frame streams immediately after the first's o_last.
- RST_N=0 for one cycle while in ST_DATA at index 2 -> o_valid is 0 the next cycle and all outputs are 0. A frame sent after release streams normally.
